// File: rtl/router_pkg.sv
// Shared types and constants for the packet generator: packet layout, LFSR constants, FSM states.
// Pure declarations; no logic or timing of its own.
package router_pkg;

    localparam int PKT_W  = 13;
    localparam int ADDR_W = 4;
    localparam int LFSR_W = 8;

    // Feedback taps at bits 7,5,4,3; an all-zero state would lock up, so reset/zero-seed use 8'h01
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_RESET = 8'h01;

    typedef struct packed {
        logic              parity;
        logic [ADDR_W-1:0] addr;
        logic [LFSR_W-1:0] payload;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/packet_gen_lfsr.sv
// Payload LFSR: loads a seed (zero maps to 8'h01) and steps once per advance.
// Value changes one cycle after load/advance; advance is the caller's handshake, so it holds under backpressure.
module pkt_lfsr
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_RESET;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_RESET : seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/packet_gen.sv
// Burst packet generator: emits num_pkts parity-protected packets with LFSR payloads to the router.
// First valid one cycle after start; one packet per cycle when ready is high and GAP_CYCLES is 0.
// valid/packet hold steady while ready is low; nothing advances until the handshake.
module packet_gen
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       num_pkts,
    input  logic [7:0]       seed,
    input  logic             inject_err,
    output logic [PKT_W-1:0] packet,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [4:0]       sent_count
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pkt_idx_q;
    logic [ADDR_W-1:0]  last_idx_q;
    logic               err_q;
    logic [GW-1:0]      gap_cnt_q;
    logic [LFSR_W-1:0]  lfsr_val;
    logic               start_acc;
    logic               hs;
    logic               is_last;
    pkt_t               pkt;

    assign start_acc = (state_q == IDLE) && start;
    assign hs        = valid && ready;
    assign is_last   = (pkt_idx_q == last_idx_q);

    pkt_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_acc),
        .seed    (seed),
        .advance (hs),
        .value   (lfsr_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEND;
            SEND: begin
                if (hs) begin
                    if (is_last)             state_d = FINISH;
                    else if (GAP_CYCLES > 0) state_d = GAP;
                    else                     state_d = SEND;
                end
            end
            GAP:     if (gap_cnt_q == GAP_LAST) state_d = SEND;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid = (state_q == SEND);
        busy  = (state_q == SEND) || (state_q == GAP);
        done  = (state_q == FINISH);
    end

    // num_pkts of 0 wraps to last index 15, giving a 16-packet burst for free
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_idx_q  <= '0;
            last_idx_q <= '0;
            err_q      <= 1'b0;
            sent_count <= '0;
            gap_cnt_q  <= '0;
        end else begin
            if (start_acc) begin
                pkt_idx_q  <= '0;
                last_idx_q <= num_pkts - 4'd1;
                err_q      <= inject_err;
                sent_count <= '0;
            end else if (hs) begin
                pkt_idx_q  <= pkt_idx_q + 4'd1;
                sent_count <= sent_count + 5'd1;
            end
            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + GW'(1) : '0;
        end
    end

    always_comb begin
        pkt.addr    = pkt_idx_q;
        pkt.payload = lfsr_val;
        pkt.parity  = ^{pkt_idx_q, lfsr_val} ^ (err_q && is_last);
        packet      = valid ? pkt : '0;
    end

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen: one instance with no gap, one with a 2-cycle gap.
module tb_packet_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic [3:0]  num_pkts;
    logic [7:0]  seed;
    logic        inject_err;
    logic        ready;

    logic [12:0] pkt0, pkt2;
    logic        valid0, valid2, busy0, busy2, done0, done2;
    logic [4:0]  sent0, sent2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    packet_gen #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .num_pkts(num_pkts), .seed(seed),
        .inject_err(inject_err), .packet(pkt0), .valid(valid0), .ready(ready),
        .busy(busy0), .done(done0), .sent_count(sent0)
    );

    packet_gen #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_pkts(num_pkts), .seed(seed),
        .inject_err(inject_err), .packet(pkt2), .valid(valid2), .ready(ready),
        .busy(busy2), .done(done2), .sent_count(sent2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [12:0] mk_pkt(input logic [3:0] a, input logic [7:0] p);
        return {^{a, p}, a, p};
    endfunction

    function automatic logic [7:0] ref_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    initial begin
        logic [7:0] m;
        int         done_cnt;

        rst = 1'b1; start0 = 0; start2 = 0; num_pkts = 0; seed = 0; inject_err = 0; ready = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_packet", pkt0, 0);
        check("rst_sent", sent0, 0);
        check("rst_valid_gap", valid2, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic two-packet burst
        seed = 8'h01; num_pkts = 4'd2; ready = 1; start0 = 1;
        @(negedge clk); start0 = 0;
        check("b2_valid0", valid0, 1);
        check("b2_busy0", busy0, 1);
        check("b2_pkt0", pkt0, 13'h1001);
        @(negedge clk);
        check("b2_pkt1", pkt0, 13'h0102);
        @(negedge clk);
        check("b2_done", done0, 1);
        check("b2_busy_fin", busy0, 0);
        check("b2_valid_fin", valid0, 0);
        check("b2_sent", sent0, 2);
        @(negedge clk);
        check("b2_done_low", done0, 0);
        check("b2_sent_hold", sent0, 2);

        // Backpressure
        ready = 0; start0 = 1;
        @(negedge clk); start0 = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_valid%0d", i), valid0, 1);
            check($sformatf("bp_pkt%0d", i), pkt0, 13'h1001);
            if (i == 3) ready = 1;
            @(negedge clk);
        end
        check("bp_pkt_next", pkt0, 13'h0102);
        check("bp_sent1", sent0, 1);
        @(negedge clk);
        check("bp_done", done0, 1);
        @(negedge clk);

        // Error injection, control changed mid-burst
        inject_err = 1; start0 = 1;
        @(negedge clk); start0 = 0; inject_err = 0;
        check("err_pkt0", pkt0, 13'h1001);
        @(negedge clk);
        check("err_pkt1", pkt0, 13'h1102);
        @(negedge clk);
        check("err_done", done0, 1);
        @(negedge clk);

        // num_pkts = 0 -> 16 packets
        seed = 8'hA5; num_pkts = 4'd0; start0 = 1; m = 8'hA5; done_cnt = 0;
        @(negedge clk); start0 = 0; num_pkts = 4'd3; seed = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b16_pkt%0d", i), {valid0, pkt0}, {1'b1, mk_pkt(4'(i), m)});
            m = ref_next(m);
            done_cnt += int'(done0);
            @(negedge clk);
        end
        check("b16_sent", sent0, 16);
        for (int i = 0; i < 4; i++) begin
            done_cnt += int'(done0);
            @(negedge clk);
        end
        check("b16_done_pulses", done_cnt, 1);

        // GAP_CYCLES=2 instance, zero seed
        seed = 8'h00; num_pkts = 4'd2; start2 = 1;
        @(negedge clk); start2 = 0;
        check("gap_pkt0", {valid2, pkt2}, {1'b1, 13'h1001});
        @(negedge clk);
        check("gap_idle1", valid2, 0);
        check("gap_busy", busy2, 1);
        @(negedge clk);
        check("gap_idle2", valid2, 0);
        @(negedge clk);
        check("gap_pkt1", {valid2, pkt2}, {1'b1, 13'h0102});
        @(negedge clk);
        check("gap_done", done2, 1);
        check("gap_sent", sent2, 2);
        @(negedge clk);

        // start while busy is ignored
        seed = 8'h01; num_pkts = 4'd3; start0 = 1;
        @(negedge clk); start0 = 0;
        check("ign_pkt0", pkt0, 13'h1001);
        start0 = 1; num_pkts = 4'd5; seed = 8'h55;
        @(negedge clk); start0 = 0;
        check("ign_pkt1", pkt0, 13'h0102);
        @(negedge clk);
        check("ign_pkt2", pkt0, 13'h0204);
        @(negedge clk);
        check("ign_done", done0, 1);
        check("ign_sent", sent0, 3);
        @(negedge clk);

        // Reset mid-burst
        seed = 8'h01; num_pkts = 4'd4; start0 = 1;
        @(negedge clk); start0 = 0;
        check("mrst_valid", valid0, 1);
        @(negedge clk);
        check("mrst_pkt1", pkt0, 13'h0102);
        rst = 1;
        @(negedge clk); rst = 0;
        check("mrst_valid_after", valid0, 0);
        check("mrst_busy_after", busy0, 0);
        check("mrst_sent_after", sent0, 0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            done_cnt += int'(done0) + int'(valid0);
            @(negedge clk);
        end
        check("mrst_no_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
